// File: rtl/rat_io_if.sv
// MCU port bus: address, write data and strobe from the MCU; read data and interrupt back to it.
interface rat_io_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        port_id;
    logic [DATA_W-1:0] out_port;
    logic              io_strb;
    logic [DATA_W-1:0] in_port;
    logic              intr;

    modport master (output port_id, output out_port, output io_strb, input in_port, input intr);
    modport slave  (input port_id, input out_port, input io_strb, output in_port, output intr);
endinterface

// File: rtl/rat_io_ctrl.sv
// MCU I/O port block: synchronized input channels with change interrupts, output registers,
// and interrupt status/mask registers, all on a single port-ID address space.
module rat_io_ctrl #(
    parameter int         DATA_W      = 8,
    parameter int         N_IN        = 4,
    parameter int         N_OUT       = 4,
    parameter logic [7:0] IN_BASE     = 8'h20,
    parameter logic [7:0] OUT_BASE    = 8'h40,
    parameter logic [7:0] IRQ_STAT_ID = 8'hF0,
    parameter logic [7:0] IRQ_MASK_ID = 8'hF1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rat_io_if.slave                 bus,
    input  logic [N_IN*DATA_W-1:0]  ext_in,
    output logic [N_OUT*DATA_W-1:0] ext_out
);

    logic [DATA_W-1:0] sync1   [N_IN];
    logic [DATA_W-1:0] sync2   [N_IN];
    logic [DATA_W-1:0] prev    [N_IN];
    logic [DATA_W-1:0] out_reg [N_OUT];
    logic [N_IN-1:0]   pend;
    logic [N_IN-1:0]   mask;
    logic [N_IN-1:0]   chg;
    logic [N_IN-1:0]   clr;
    logic [N_IN-1:0]   in_sel;
    logic [N_OUT-1:0]  out_sel;
    logic              is_stat;
    logic              is_mask;
    logic              in_hit;
    logic [DATA_W-1:0] rd_data;

    // Address decode with priority status > mask > input range > output range.
    always_comb begin
        is_stat = (bus.port_id == IRQ_STAT_ID);
        is_mask = (bus.port_id == IRQ_MASK_ID) && !is_stat;
        in_sel  = '0;
        for (int k = 0; k < N_IN; k++) begin
            in_sel[k] = (bus.port_id == 8'(IN_BASE + k)) && !is_stat && !is_mask;
        end
        in_hit  = |in_sel;
        out_sel = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_sel[k] = (bus.port_id == 8'(OUT_BASE + k)) && !is_stat && !is_mask && !in_hit;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (out_sel[k]) rd_data = out_reg[k];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel[k]) rd_data = sync2[k];
        end
        if (is_mask) rd_data = DATA_W'(mask);
        if (is_stat) rd_data = DATA_W'(pend);
    end

    always_comb begin
        chg = '0;
        for (int k = 0; k < N_IN; k++) begin
            chg[k] = |(sync2[k] ^ prev[k]);
        end
        clr = (bus.io_strb && is_stat) ? bus.out_port[N_IN-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= '0;
                sync2[k] <= '0;
                prev[k]  <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                out_reg[k] <= '0;
            end
            pend <= '0;
            mask <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= ext_in[k*DATA_W +: DATA_W];
                sync2[k] <= sync1[k];
                prev[k]  <= sync2[k];
            end
            // A new change outranks a simultaneous write-1-to-clear.
            pend <= (pend & ~clr) | chg;
            if (bus.io_strb && is_mask) mask <= bus.out_port[N_IN-1:0];
            for (int k = 0; k < N_OUT; k++) begin
                if (bus.io_strb && out_sel[k]) out_reg[k] <= bus.out_port;
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_ext_out
        assign ext_out[k*DATA_W +: DATA_W] = out_reg[k];
    end

    assign bus.in_port = rd_data;
    assign bus.intr    = |(pend & mask);

endmodule

// File: tb/tb_rat_io_ctrl.sv
// Bench for rat_io_ctrl: history-based reference model checked every cycle, plus directed scenarios.
module tb_rat_io_ctrl;
    localparam int DW = 8;
    localparam int NI = 4;
    localparam int NO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rat_io_if #(.DATA_W(DW)) bus ();
    logic [NI*DW-1:0] ext_in;
    logic [NO*DW-1:0] ext_out;

    rat_io_ctrl #(
        .DATA_W(DW), .N_IN(NI), .N_OUT(NO),
        .IN_BASE(8'h20), .OUT_BASE(8'h40), .IRQ_STAT_ID(8'hF0), .IRQ_MASK_ID(8'hF1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ext_in(ext_in), .ext_out(ext_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Model: h1/h2/h3 are the external input values sampled 1, 2 and 3 edges ago.
    logic [DW-1:0] h1 [NI];
    logic [DW-1:0] h2 [NI];
    logic [DW-1:0] h3 [NI];
    logic [DW-1:0] m_out [NO];
    logic [NI-1:0] m_pend, m_mask, m_set, m_clr;

    function automatic logic [DW-1:0] m_read(input logic [7:0] id);
        int i;
        i = int'(id);
        if (id == 8'hF0) return DW'(m_pend);
        if (id == 8'hF1) return DW'(m_mask);
        if (i >= 'h20 && i < 'h20 + NI) return h2[i - 'h20];
        if (i >= 'h40 && i < 'h40 + NO) return m_out[i - 'h40];
        return '0;
    endfunction

    function automatic logic [NO*DW-1:0] m_ext_out();
        logic [NO*DW-1:0] v;
        for (int k = 0; k < NO; k++) v[k*DW +: DW] = m_out[k];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                h1[k] = '0; h2[k] = '0; h3[k] = '0;
            end
            for (int k = 0; k < NO; k++) m_out[k] = '0;
            m_pend = '0;
            m_mask = '0;
        end else begin
            for (int k = 0; k < NI; k++) m_set[k] = (h2[k] != h3[k]);
            m_clr = (bus.io_strb && bus.port_id == 8'hF0) ? bus.out_port[NI-1:0] : '0;
            if (bus.io_strb && bus.port_id == 8'hF1) m_mask = bus.out_port[NI-1:0];
            if (bus.io_strb && int'(bus.port_id) >= 'h40 && int'(bus.port_id) < 'h40 + NO)
                m_out[int'(bus.port_id) - 'h40] = bus.out_port;
            m_pend = (m_pend & ~m_clr) | m_set;
            for (int k = 0; k < NI; k++) begin
                h3[k] = h2[k];
                h2[k] = h1[k];
                h1[k] = ext_in[k*DW +: DW];
            end
            #1;
            if (rst_n) begin
                check("cyc_in_port", 32'(bus.in_port), 32'(m_read(bus.port_id)));
                check("cyc_ext_out", ext_out, m_ext_out());
                check("cyc_intr", 32'(bus.intr), 32'(|(m_pend & m_mask)));
            end
        end
    end

    task automatic wr(input logic [7:0] id, input logic [DW-1:0] data);
        @(negedge clk);
        bus.port_id  = id;
        bus.out_port = data;
        bus.io_strb  = 1'b1;
        @(negedge clk);
        bus.io_strb  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] id, input logic [DW-1:0] exp);
        bus.port_id = id;
        #1;
        check(name, 32'(bus.in_port), 32'(exp));
    endtask

    initial begin
        bus.port_id  = 8'h00;
        bus.out_port = '0;
        bus.io_strb  = 1'b0;
        ext_in       = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_ext_out", ext_out, 32'h0);
        check("rst_intr", 32'(bus.intr), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("rst_pend", 8'hF0, 8'h00);

        wr(8'h41, 8'hA5);
        check("w41_ext_out", ext_out, 32'h0000A500);
        rd_chk("rd41", 8'h41, 8'hA5);

        wr(8'hF1, 8'hF4);
        rd_chk("mask_hi_ignored", 8'hF1, 8'h04);

        bus.port_id = 8'h22;
        ext_in[16 +: 8] = 8'h3C;
        @(posedge clk); #2;
        check("ch2_edge1", 32'(bus.in_port), 32'h00);
        @(posedge clk); #2;
        check("ch2_edge2", 32'(bus.in_port), 32'h3C);
        check("intr_edge2", 32'(bus.intr), 32'h0);
        @(posedge clk); #2;
        check("intr_edge3", 32'(bus.intr), 32'h1);
        @(negedge clk);
        rd_chk("stat_ch2", 8'hF0, 8'h04);

        wr(8'hF0, 8'h01);
        rd_chk("clr_other_bit", 8'hF0, 8'h04);
        check("intr_kept", 32'(bus.intr), 32'h1);
        wr(8'hF0, 8'h04);
        check("intr_cleared", 32'(bus.intr), 32'h0);
        rd_chk("stat_cleared", 8'hF0, 8'h00);

        @(negedge clk);
        ext_in[0 +: 8] = 8'h11;
        @(negedge clk);
        @(negedge clk);
        bus.port_id  = 8'hF0;
        bus.out_port = 8'h01;
        bus.io_strb  = 1'b1;
        @(negedge clk);
        bus.io_strb  = 1'b0;
        rd_chk("set_beats_clr", 8'hF0, 8'h01);

        rd_chk("unmapped_rd", 8'h30, 8'h00);
        wr(8'h30, 8'hFF);
        wr(8'h20, 8'hFF);
        wr(8'h44, 8'h11);
        rd_chk("rd44", 8'h44, 8'h00);
        check("unmapped_wr", ext_out, 32'h0000A500);
        rd_chk("unmapped_mask", 8'hF1, 8'h04);
        rd_chk("unmapped_pend", 8'hF0, 8'h01);

        bus.port_id  = 8'h40;
        bus.out_port = 8'h99;
        repeat (2) @(negedge clk);
        check("no_strb", ext_out, 32'h0000A500);

        wr(8'h40, 8'h5A);
        wr(8'h43, 8'hC3);
        check("multi_out", ext_out, 32'hC300A55A);
        wr(8'hF1, 8'h05);
        check("intr_pre_rst", 32'(bus.intr), 32'h1);

        #1 rst_n = 1'b0;
        #1;
        check("pulse_ext_out", ext_out, 32'h0);
        check("pulse_intr", 32'(bus.intr), 32'h0);
        rd_chk("pulse_mask", 8'hF1, 8'h00);
        rd_chk("pulse_pend", 8'hF0, 8'h00);
        rst_n = 1'b1;

        repeat (3) @(negedge clk);
        rd_chk("release_pend", 8'hF0, 8'h05);
        check("release_intr", 32'(bus.intr), 32'h0);

        @(negedge clk);
        bus.port_id  = 8'h42;
        bus.out_port = 8'h77;
        bus.io_strb  = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus.io_strb = 1'b0;
        check("midwrite_ext_out", ext_out, 32'h0);
        rd_chk("midwrite_rd42", 8'h42, 8'h00);

        wr(8'h42, 8'h77);
        check("post_rst_write", ext_out, 32'h00770000);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rat_io_ctrl.md
RAT_IO_CTRL -- requirements
Module: rat_io_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of every data port and port register.
REQ-002 Parameter N_IN, default 4: number of input channels, 1..DATA_W.
REQ-003 Parameter N_OUT, default 4: number of output registers, 1..16.
REQ-004 Parameter IN_BASE, default 8'h20: PORT_ID of input channel 0; channel k is at IN_BASE+k.
REQ-005 Parameter OUT_BASE, default 8'h40: PORT_ID of output register 0; register k is at OUT_BASE+k.
REQ-006 Parameters IRQ_STAT_ID, default 8'hF0, and IRQ_MASK_ID, default 8'hF1: interrupt status and mask port IDs.
REQ-007 CLK  in  1  system clock; all state changes on its rising edge.
REQ-008 RESET_N  in  1  reset, asynchronous, active-low.
REQ-009 PORT_ID  in  8  port address from the MCU.
REQ-010 OUT_PORT  in  DATA_W  write data from the MCU.
REQ-011 IO_STRB  in  1  write strobe; one CLK cycle per write.
REQ-012 IN_PORT  out  DATA_W  read data to the MCU, combinational from PORT_ID.
REQ-013 EXT_IN  in  N_IN*DATA_W  asynchronous external inputs; channel k is bits [k*DATA_W +: DATA_W].
REQ-014 EXT_OUT  out  N_OUT*DATA_W  output register contents, packed the same way.
REQ-015 INTR  out  1  level interrupt request to the MCU.

Function
REQ-016 Each EXT_IN bit SHALL pass through a two-flop synchronizer; SYNC denotes the second flop.
REQ-017 A per-channel PREV register SHALL capture SYNC every cycle.
REQ-018 Any bit difference between SYNC and PREV on channel k SHALL set PEND[k] on the next edge.
REQ-019 INTR SHALL equal the OR-reduction of (PEND AND MASK), with no extra register stage.
REQ-020 Latency: an EXT_IN change stable before edge 1 appears on IN_PORT after edge 2, and on INTR after edge 3 when masked in.
REQ-021 IN_PORT decode for PORT_ID = IN_BASE+k, k<N_IN: SYNC of channel k.
REQ-022 IN_PORT decode for PORT_ID = IRQ_STAT_ID: PEND, zero-extended.
REQ-023 IN_PORT decode for PORT_ID = IRQ_MASK_ID: MASK, zero-extended.
REQ-024 IN_PORT decode for PORT_ID = OUT_BASE+k, k<N_OUT: output register k (readback).
REQ-025 IN_PORT decode for any other PORT_ID: 0.
REQ-026 Decode priority: IRQ_STAT_ID, IRQ_MASK_ID, input range, output range.
REQ-027 With IO_STRB=1 and PORT_ID=OUT_BASE+k, k<N_OUT, register k SHALL load OUT_PORT on that edge and EXT_OUT SHALL show it immediately after.
REQ-028 With IO_STRB=1 and PORT_ID=IRQ_MASK_ID, MASK SHALL load OUT_PORT[N_IN-1:0].
REQ-029 With IO_STRB=1 and PORT_ID=IRQ_STAT_ID, each PEND bit with OUT_PORT bit =1 SHALL clear (write-1-to-clear); 0 bits leave PEND unchanged.
REQ-030 If a PEND bit is set and cleared on the same edge, the set SHALL win.
REQ-031 Writes to unmapped or input IDs SHALL have no effect; IO_STRB=0 SHALL never change registers.
REQ-032 OUT_PORT bits above N_IN SHALL be ignored for MASK and PEND writes.
REQ-033 PEND bits SHALL set regardless of MASK; MASK gates INTR only.

Reset
REQ-034 RESET_N=0 SHALL immediately, without waiting for CLK, clear synchronizers, PREV, PEND, MASK and all output registers.
REQ-035 During reset, EXT_OUT, INTR and PEND SHALL read 0.
REQ-036 Reset mid-write SHALL discard the write; reset release SHALL be followed by normal operation from the next edge.
REQ-037 A nonzero EXT_IN present at reset release SHALL count as a change and set PEND; MASK=0 keeps INTR low.

Verification
REQ-038 Write 8'hA5 to ID 8'h41 -> EXT_OUT[15:8]=8'hA5 after that edge, other registers 0; read 8'h41 -> 8'hA5.
REQ-039 EXT_IN ch2 0->8'h3C with MASK=4'b0100 -> IN_PORT at 8'h22 =8'h3C after 2 edges, INTR=1 after edge 3, read 8'hF0 -> 8'h04.
REQ-040 Pending ch2 with write 8'h04 to 8'hF0 -> INTR=0 next cycle; write 8'h01 instead -> PEND unchanged.
REQ-041 Ch0 change arriving at PEND on the same edge as a clear of bit 0 -> PEND[0] stays 1.
REQ-042 RESET_N pulsed low between edges after writes -> EXT_OUT, MASK, PEND all 0 before the next edge.
REQ-043 Read 8'h30 and write 8'h30 -> IN_PORT 0, no state change.
